digit_scan_ctrl: RTL

Two-digit display scan controller that sits directly upstream of the per-bit mux_2_1 instances in the digit display path. It latches two 4-bit digit values once per refresh frame and presents them as the mux `a`/`b` operands. It drives the mux select and the active-low anode enables through a four-state time-multiplexing sequence. Blanking gaps around each select change prevent ghosting.

---
 rtl/digit_scan_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/digit_scan_ctrl.sv
// Two-digit display scan controller: latches a digit pair once per frame and
// sequences mux select plus active-low anode enables with blanking gaps.
module digit_scan_ctrl #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit0_in,
  input  logic [3:0] digit1_in,
  input  logic       lz_blank,
  output logic [3:0] digit0_q,
  output logic [3:0] digit1_q,
  output logic       sel,
  output logic [1:0] an,
  output logic       blank,
  output logic       frame_start
);

  localparam int MAX_LEN = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  generate
    if (DIV < 1 || BLANK_CYC < 1) begin : g_bad_params
      $error("digit_scan_ctrl: DIV and BLANK_CYC must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_SHOW0 = 2'd0,
    S_GAP0  = 2'd1,
    S_SHOW1 = 2'd2,
    S_GAP1  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_last;

  logic [3:0]      digit0_d, digit1_d;
  logic            lz_q, lz_d;
  logic            sel_q, sel_d;
  logic [1:0]      an_q, an_d;
  logic            blank_q, blank_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_load;
  logic            suppress1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_GAP1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_last = 1'b0;
    case (state_q)
      S_SHOW0, S_SHOW1: phase_last = (cnt_q == DIV_LAST);
      default:          phase_last = (cnt_q == BLANK_LAST);
    endcase
    if (en) begin
      if (phase_last) begin
        cnt_d = '0;
        case (state_q)
          S_SHOW0: state_d = S_GAP0;
          S_GAP0:  state_d = S_SHOW1;
          S_SHOW1: state_d = S_GAP1;
          default: state_d = S_SHOW0;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output logic; outputs trail the state by one cycle, so the first
  // enabled cycle spent in SHOW0 is what launches the frame.
  always_comb begin
    frame_load    = en && (state_q == S_SHOW0) && (cnt_q == '0);
    suppress1     = lz_q && (digit1_q == 4'd0);
    frame_start_d = frame_load;
    digit0_d      = frame_load ? digit0_in : digit0_q;
    digit1_d      = frame_load ? digit1_in : digit1_q;
    lz_d          = frame_load ? lz_blank  : lz_q;
    sel_d         = sel_q;
    an_d          = an_q;
    blank_d       = blank_q;
    if (en) begin
      case (state_q)
        S_SHOW0: begin
          sel_d   = 1'b0;
          an_d    = 2'b10;
          blank_d = 1'b0;
        end
        S_GAP0: begin
          sel_d   = 1'b1;
          an_d    = 2'b11;
          blank_d = 1'b1;
        end
        S_SHOW1: begin
          // Select stays on digit 1 even when it is suppressed
          sel_d   = 1'b1;
          an_d    = suppress1 ? 2'b11 : 2'b01;
          blank_d = suppress1;
        end
        default: begin
          sel_d   = 1'b0;
          an_d    = 2'b11;
          blank_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit0_q      <= 4'd0;
      digit1_q      <= 4'd0;
      lz_q          <= 1'b0;
      sel_q         <= 1'b0;
      an_q          <= 2'b11;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      digit0_q      <= digit0_d;
      digit1_q      <= digit1_d;
      lz_q          <= lz_d;
      sel_q         <= sel_d;
      an_q          <= an_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign an          = an_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

endmodule
